// File: rtl/la_loopback_sched.sv
// Purpose : scheduled LA loopback that captures one word from a granted SoC-driven bank and replays it on the partner bank; optional LA_SCHED_CNT_EN adds the completed-transfer counter.
// Latency : grant, capture, then HOLD_CYCLES drive cycles and one release cycle; output is valid 2 cycles after the request and each transfer takes HOLD_CYCLES+3 cycles.
// Backpres: none; if the SoC withdraws the request (enable low or the oenb pattern changes) during drive, the transfer aborts and outputs go to 0 on the next cycle.
module la_loopback_sched #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             wb_clk_i,
   input  logic             resetn,
   input  logic             enable,
   input  logic [127:0]     la_data_in,
   input  logic [127:0]     la_oenb,
   output logic [127:0]     la_data_out,
   output logic [3:0]       bank_busy,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRIVE   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  req;
   logic        arb_vld;
   logic [1:0]  arb_gnt;
   logic [1:0]  arb_idx;
   logic [1:0]  gnt;
   logic [1:0]  last_gnt;
   logic [1:0]  partner;
   logic [31:0] data_reg;
   logic [7:0]  hold_cnt;

   // A bank requests when it is fully SoC-driven and its partner is fully SoC-read.
   always_comb begin
      req = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         req[b] = enable
                  && (la_oenb[32*b +: 32] == 32'h0000_0000)
                  && (la_oenb[32*(b^1) +: 32] == 32'hFFFF_FFFF);
      end
   end

   // Round-robin search from last_gnt+1; iterating far-to-near leaves the nearest requester.
   always_comb begin
      arb_vld = 1'b0;
      arb_gnt = 2'd0;
      arb_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         arb_idx = last_gnt + 2'(i + 1);
         if (req[arb_idx]) begin
            arb_vld = 1'b1;
            arb_gnt = arb_idx;
         end
      end
   end

   // State register.
   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; a dropped request wins over an expiring hold count.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (arb_vld) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_DRIVE;
         ST_DRIVE:   if (!req[gnt] || (hold_cnt == 8'd0)) state_nxt = ST_RELEASE;
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Grant, captured word, hold counter and round-robin pointer.
   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         gnt      <= 2'd0;
         last_gnt <= 2'd3;
         data_reg <= 32'h0;
         hold_cnt <= 8'd0;
      end else begin
         if (state == ST_IDLE && arb_vld) begin
            gnt <= arb_gnt;
         end
         if (state == ST_CAPTURE) begin
            data_reg <= la_data_in[32*gnt +: 32];
            hold_cnt <= 8'(HOLD_CYCLES - 1);
         end else if (state == ST_DRIVE && state_nxt == ST_DRIVE) begin
            hold_cnt <= hold_cnt - 8'd1;
         end
         if (state == ST_RELEASE) begin
            last_gnt <= gnt;
         end
      end
   end

   assign partner = gnt ^ 2'b01;

   // Outputs decode only from registered state, so reset clears them asynchronously.
   always_comb begin
      la_data_out = '0;
      bank_busy   = 4'b0000;
      if (state == ST_DRIVE) begin
         la_data_out[32*partner +: 32] = data_reg;
         bank_busy[partner]            = 1'b1;
      end
   end

`ifdef LA_SCHED_CNT_EN
   logic xfer_ok;

   // xfer_ok holds the request level seen on the DRIVE exit edge: high means completed, low means aborted.
   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         xfer_ok  <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         if (state == ST_DRIVE) begin
            xfer_ok <= req[gnt];
         end
         if (state == ST_RELEASE && xfer_ok) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_la_loopback_sched.sv
module tb_la_loopback_sched;

   localparam int HOLD = 4;
   localparam int CW   = 4;

   logic          wb_clk_i = 1'b0;
   logic          resetn;
   logic          enable;
   logic [127:0]  la_data_in;
   logic [127:0]  la_oenb;
   logic [127:0]  la_data_out;
   logic [3:0]    bank_busy;
   logic [CW-1:0] xfer_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   la_loopback_sched #(
      .HOLD_CYCLES (HOLD),
      .CNT_W       (CW)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .resetn      (resetn),
      .enable      (enable),
      .la_data_in  (la_data_in),
      .la_oenb     (la_oenb),
      .la_data_out (la_data_out),
      .bank_busy   (bank_busy),
      .xfer_cnt    (xfer_cnt)
   );

   function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef LA_SCHED_CNT_EN
      return CW'(n);
`else
      return '0;
`endif
   endfunction

   task automatic set_req(input int src);
      la_oenb[32*src +: 32]     = 32'h0000_0000;
      la_oenb[32*(src^1) +: 32] = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      enable     = 1'b0;
      la_oenb    = '1;
      la_data_in = '0;
      repeat (2) @(negedge wb_clk_i);
      resetn = 1'b1;
      @(negedge wb_clk_i);
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      enable     = 1'b1;
      la_data_in = {$urandom, $urandom, $urandom, $urandom};
      la_oenb    = {$urandom, $urandom, $urandom, $urandom};
      set_req(0);
      for (int t = 0; t < 3; t++) begin
         @(negedge wb_clk_i);
         n_checks++;
         if (la_data_out !== 128'h0) begin
            n_fail++; $display("FAIL reset_hold_data: got %h expected 0", la_data_out);
         end
         n_checks++;
         if (bank_busy !== 4'b0000) begin
            n_fail++; $display("FAIL reset_hold_busy: got %b expected 0000", bank_busy);
         end
         n_checks++;
         if (xfer_cnt !== '0) begin
            n_fail++; $display("FAIL reset_hold_cnt: got %0d expected 0", xfer_cnt);
         end
      end
      enable  = 1'b0;
      la_oenb = '1;
      resetn  = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge wb_clk_i);
         n_checks++;
         if (la_data_out !== 128'h0 || bank_busy !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release_idle: got data %h busy %b expected 0", la_data_out, bank_busy);
         end
      end
   endtask

   task automatic test_single_transfer();
      logic [127:0] exp_out;
      logic [3:0]   exp_busy;
      do_reset();
      enable = 1'b1;
      set_req(0);
      la_data_in[31:0]   = 32'hDEADBEEF;
      la_data_in[63:32]  = 32'h0BAD_F00D;
      for (int t = 1; t <= 7; t++) begin
         @(negedge wb_clk_i);
         exp_out  = '0;
         exp_busy = 4'b0000;
         if (t >= 2 && t <= 5) begin
            exp_out[63:32] = 32'hDEADBEEF;
            exp_busy       = 4'b0010;
         end
         n_checks++;
         if (la_data_out !== exp_out) begin
            n_fail++; $display("FAIL single_data t=%0d: got %h expected %h", t, la_data_out, exp_out);
         end
         n_checks++;
         if (bank_busy !== exp_busy) begin
            n_fail++; $display("FAIL single_busy t=%0d: got %b expected %b", t, bank_busy, exp_busy);
         end
         if (t == 3) la_data_in[31:0] = 32'h1234_5678;
         if (t == 6) enable = 1'b0;
      end
      n_checks++;
      if (xfer_cnt !== exp_cnt(1)) begin
         n_fail++; $display("FAIL single_cnt: got %0d expected %0d", xfer_cnt, exp_cnt(1));
      end
   endtask

   task automatic test_round_robin();
      logic [127:0] exp_out;
      logic [3:0]   exp_busy;
      int k;
      int ph;
      do_reset();
      la_data_in[31:0]   = 32'hA0A0_A0A0;
      la_data_in[63:32]  = 32'h1111_1111;
      la_data_in[95:64]  = 32'hC2C2_C2C2;
      la_data_in[127:96] = 32'h3333_3333;
      set_req(0);
      set_req(2);
      enable = 1'b1;
      for (int t = 1; t <= 28; t++) begin
         @(negedge wb_clk_i);
         k  = (t - 1) / 7;
         ph = (t - 1) % 7;
         exp_out  = '0;
         exp_busy = 4'b0000;
         if (ph >= 1 && ph <= 4) begin
            if (k % 2 == 0) begin
               exp_out[63:32] = 32'hA0A0_A0A0;
               exp_busy       = 4'b0010;
            end else begin
               exp_out[127:96] = 32'hC2C2_C2C2;
               exp_busy        = 4'b1000;
            end
         end
         n_checks++;
         if (la_data_out !== exp_out) begin
            n_fail++; $display("FAIL rr_data t=%0d: got %h expected %h", t, la_data_out, exp_out);
         end
         n_checks++;
         if (bank_busy !== exp_busy) begin
            n_fail++; $display("FAIL rr_busy t=%0d: got %b expected %b", t, bank_busy, exp_busy);
         end
      end
      enable = 1'b0;
      n_checks++;
      if (xfer_cnt !== exp_cnt(4)) begin
         n_fail++; $display("FAIL rr_cnt: got %0d expected %0d", xfer_cnt, exp_cnt(4));
      end
   endtask

   task automatic test_abort();
      logic [127:0] exp_out;
      do_reset();
      la_data_in[31:0]   = 32'h1111_1111;
      la_data_in[127:96] = 32'h3333_3333;
      set_req(0);
      enable = 1'b1;
      @(negedge wb_clk_i);
      n_checks++;
      if (la_data_out !== 128'h0) begin
         n_fail++; $display("FAIL abort_capture: got %h expected 0", la_data_out);
      end
      for (int t = 2; t <= 3; t++) begin
         @(negedge wb_clk_i);
         exp_out = '0;
         exp_out[63:32] = 32'h1111_1111;
         n_checks++;
         if (la_data_out !== exp_out) begin
            n_fail++; $display("FAIL abort_drive t=%0d: got %h expected %h", t, la_data_out, exp_out);
         end
      end
      enable = 1'b0;
      @(negedge wb_clk_i);
      n_checks++;
      if (la_data_out !== 128'h0 || bank_busy !== 4'b0000) begin
         n_fail++; $display("FAIL abort_zero: got data %h busy %b expected 0", la_data_out, bank_busy);
      end
      @(negedge wb_clk_i);
      n_checks++;
      if (xfer_cnt !== exp_cnt(0)) begin
         n_fail++; $display("FAIL abort_cnt: got %0d expected %0d", xfer_cnt, exp_cnt(0));
      end
      set_req(0);
      set_req(3);
      enable = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      exp_out = '0;
      exp_out[95:64] = 32'h3333_3333;
      n_checks++;
      if (la_data_out !== exp_out) begin
         n_fail++; $display("FAIL abort_next_data: got %h expected %h", la_data_out, exp_out);
      end
      n_checks++;
      if (bank_busy !== 4'b0100) begin
         n_fail++; $display("FAIL abort_next_busy: got %b expected 0100", bank_busy);
      end
      enable = 1'b0;
      repeat (3) @(negedge wb_clk_i);
   endtask

   task automatic test_async_reset();
      logic [127:0] exp_out;
      do_reset();
      la_data_in[31:0]  = 32'h0F0F_0F0F;
      la_data_in[95:64] = 32'h5A5A_5A5A;
      set_req(2);
      enable = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      exp_out = '0;
      exp_out[127:96] = 32'h5A5A_5A5A;
      n_checks++;
      if (la_data_out !== exp_out || bank_busy !== 4'b1000) begin
         n_fail++; $display("FAIL areset_pre: got data %h busy %b expected %h 1000", la_data_out, bank_busy, exp_out);
      end
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (la_data_out !== 128'h0) begin
         n_fail++; $display("FAIL areset_data: got %h expected 0", la_data_out);
      end
      n_checks++;
      if (bank_busy !== 4'b0000) begin
         n_fail++; $display("FAIL areset_busy: got %b expected 0000", bank_busy);
      end
      @(negedge wb_clk_i);
      resetn = 1'b1;
      set_req(0);
      repeat (2) @(negedge wb_clk_i);
      exp_out = '0;
      exp_out[63:32] = 32'h0F0F_0F0F;
      n_checks++;
      if (la_data_out !== exp_out) begin
         n_fail++; $display("FAIL areset_first_data: got %h expected %h", la_data_out, exp_out);
      end
      n_checks++;
      if (bank_busy !== 4'b0010) begin
         n_fail++; $display("FAIL areset_first_busy: got %b expected 0010", bank_busy);
      end
      enable = 1'b0;
      repeat (3) @(negedge wb_clk_i);
   endtask

   task automatic test_counter_wrap();
      do_reset();
      la_data_in[31:0] = 32'hCAFE_0001;
      set_req(0);
      enable = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         repeat (7) @(negedge wb_clk_i);
         if (k == 16) enable = 1'b0;
         n_checks++;
         if (xfer_cnt !== exp_cnt(k)) begin
            n_fail++; $display("FAIL cnt_wrap k=%0d: got %0d expected %0d", k, xfer_cnt, exp_cnt(k));
         end
      end
   endtask

   initial begin
      resetn     = 1'b0;
      enable     = 1'b0;
      la_oenb    = '1;
      la_data_in = '0;
      test_reset();
      test_single_transfer();
      test_round_robin();
      test_abort();
      test_async_reset();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/la_loopback_sched.md
# la_loopback_sched

Sequenced logic-analyzer loopback scheduler for the user project area. It owns the four 32-bit LA banks: 0 and 1 form a pair, and 2 and 3 form a pair. It round-robins between banks that the SoC is actively driving. For each granted bank it captures one 32-bit word into a single shared register and replays that word on the partner bank's `la_data_out` for a programmable number of cycles. It replaces free-running combinational mirroring with a timed, one-transfer-at-a-time handshake that firmware and the bench can count.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4, legal range 1..255. Number of cycles a captured word is driven on the partner bank.
- `CNT_W`, default 16. Width of the completed-transfer counter.

Ports:
- `wb_clk_i`  in  1  Single clock.
- `resetn`  in  1  Reset, asynchronous and active-low.
- `enable`  in  1  Scheduler enable. When low, no new grants are issued and any active transfer is aborted.
- `la_data_in`  in  128  LA data from the SoC. Bank b occupies bits [32b+31:32b].
- `la_oenb`  in  128  LA output-enable-bar from the SoC. A 0 bit means the SoC drives that line.
- `la_data_out`  out  128  LA data to the SoC. Every bit not being replayed is 0; the block never drives z.
- `bank_busy`  out  4  One-hot destination bank currently being driven (DRIVE state only).
- `xfer_cnt`  out  `CNT_W`  Number of completed transfers. Present only with `LA_SCHED_CNT_EN`; otherwise it is constant 0.

## Operation
- Partner mapping: p(0)=1, p(1)=0, p(2)=3, p(3)=2.
- Request for bank b: `req[b] = enable & (la_oenb[src b]==32'h0) & (la_oenb[dst p(b)]==32'hFFFF_FFFF)`. This means the source is fully SoC-driven and the destination is fully SoC-read.
- Because of this definition, at most one bank of each pair can request at a time. Up to two requests can be active at once, for example banks 0 and 2.
- Round-robin arbitration: the search starts at `(last_gnt+1) mod 4` and the first requesting bank wins. `last_gnt` resets to 3, so bank 0 has first priority.
- FSM states: IDLE, CAPTURE, DRIVE, RELEASE.
  - IDLE: if any `req` is set, latch `gnt` and go to CAPTURE. Otherwise stay in IDLE.
  - CAPTURE: `data_reg <= la_data_in[gnt]`, `hold_cnt <= HOLD_CYCLES-1`, go to DRIVE.
  - DRIVE: `la_data_out[p(gnt)] = data_reg` and `bank_busy[p(gnt)] = 1`.
    - If `req[gnt]` drops, set abort and go to RELEASE.
    - Else if `hold_cnt==0`, mark the transfer complete and go to RELEASE.
    - Otherwise decrement `hold_cnt`.
  - RELEASE: all outputs are 0 (one turnaround cycle). `last_gnt <= gnt`. If the transfer completed (no abort), `xfer_cnt` increments. Go to IDLE.
- An aborted transfer still updates `last_gnt`. It does not increment `xfer_cnt`.
- `xfer_cnt` wraps modulo 2^`CNT_W` and never saturates.
- `la_data_out` and `bank_busy` are driven from registers (state, `gnt`, `data_reg`) through decode only. There is no path from `la_data_in` to the outputs.

## Timing
- Reset (asynchronous assert, synchronous deassert in the clock domain):
  - State is IDLE.
  - `gnt=0`, `last_gnt=3`, `data_reg=0`, `hold_cnt=0`.
  - `la_data_out=0`, `bank_busy=0`, `xfer_cnt=0`.
- Reset asserted mid-transfer forces the outputs to 0 immediately, without waiting for a clock edge.
- Sequence for a request first sampled at edge N:
  - Edge N: the grant is latched.
  - Edge N+1: the data is captured.
  - Edges N+2 .. N+1+`HOLD_CYCLES`: the outputs are valid.
  - Next cycle: RELEASE.
  - Following cycle: IDLE.
- Back-to-back transfers take `HOLD_CYCLES+3` cycles each.
- The captured word is frozen during DRIVE. Changes to `la_data_in` after CAPTURE are ignored.
- Abort: if `req[gnt]` is low at the sampling edge, `la_data_out` is 0 in the very next cycle.
- Simultaneous abort and `hold_cnt==0` on the same edge counts as an abort.

## Configuration
- `LA_SCHED_CNT_EN`
  - Defined: the `CNT_W`-bit completed-transfer counter is implemented and drives `xfer_cnt`.
  - Undefined: no counter flops are built and `xfer_cnt` is tied to 0.
  - The FSM, arbitration and data path are identical in both builds.

## Test plan
- Reset check: hold `resetn=0` with random `la_data_in`/`la_oenb` -> all outputs are 0. Release reset with no requests -> outputs stay 0.
- Single transfer:
  - Stimulus: `HOLD_CYCLES=4`, `enable=1`, bank 0 `oenb=0`, bank 1 `oenb=all ones`, `la_data_in[31:0]=32'hDEADBEEF`.
  - Response: `la_data_out[63:32]=32'hDEADBEEF` and `bank_busy=4'b0010` for exactly 4 cycles starting 2 cycles after the request. Then 0. `xfer_cnt=1`.
- Round-robin: banks 0 and 2 request continuously -> grant order 0,2,0,2. Each destination is driven for 4 cycles, with a 7-cycle transfer period.
- Abort: drop `enable` in the 2nd DRIVE cycle -> `la_data_out=0` in the next cycle, `xfer_cnt` unchanged, and the next grant goes to bank 1+ in round-robin order.
- Async reset mid-DRIVE: pulse `resetn` low between clock edges -> outputs are 0 immediately. After release, the first grant goes to bank 0.
- Counter wrap (`LA_SCHED_CNT_EN`, `CNT_W=4`): 16 completed transfers -> `xfer_cnt=0`. Without the macro, `xfer_cnt` stays 0 throughout.
